// File: rtl/adc_scan_sched.sv
// ADC0809 channel scheduler: round-robin scan of enabled inputs, on-demand requests
// with priority, one conversion at a time via start/done handshake, per-channel result store.
module adc_scan_sched #(
    parameter int SETUP_CYC = 4,
    parameter int GAP_CYC   = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] ch_mask,
    input  logic       req_valid,
    input  logic [2:0] req_ch,
    output logic       req_ready,
    output logic [2:0] conv_ch,
    output logic       conv_start,
    input  logic       conv_done,
    input  logic [7:0] conv_data,
    output logic       res_valid,
    output logic [2:0] res_ch,
    output logic       res_src,
    output logic [7:0] res_data,
    output logic       timeout_err,
    output logic       busy,
    input  logic [2:0] rd_ch,
    output logic [7:0] rd_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  ch;
    logic        src;
    logic [2:0]  scan_ptr;
    logic [7:0]  data_q;
    logic [7:0]  regfile [8];
    logic [2:0]  scan_next;
    logic [2:0]  idx;
    logic        expired;

    // scan_ptr holds the first candidate channel; walk downwards so the nearest set bit wins
    always_comb begin
        scan_next = scan_ptr;
        idx       = scan_ptr;
        for (int i = 7; i >= 0; i--) begin
            idx = scan_ptr + 3'(i);
            if (ch_mask[idx]) begin
                scan_next = idx;
            end
        end
    end

    assign expired = (cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ch       <= '0;
            src      <= 1'b0;
            scan_ptr <= '0;
            data_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        ch    <= req_ch;
                        src   <= 1'b1;
                        state <= S_SETUP;
                    end else if (enable && (ch_mask != 8'd0)) begin
                        ch       <= scan_next;
                        src      <= 1'b0;
                        scan_ptr <= scan_next + 3'd1;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == 16'(SETUP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_ISSUE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // a done arriving in the expiry cycle still counts as success
                    if (conv_done) begin
                        data_q <= conv_data;
                        cnt    <= '0;
                        state  <= S_STORE;
                    end else if (expired) begin
                        cnt   <= '0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_STORE: begin
                    cnt   <= '0;
                    state <= S_GAP;
                end
                S_GAP: begin
                    if ((GAP_CYC == 0) || (cnt == 16'(GAP_CYC - 1))) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // reading a channel in the cycle it is written returns the previous value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regfile[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (state == S_STORE) begin
                regfile[ch] <= data_q;
            end
            rd_data <= regfile[rd_ch];
        end
    end

    assign req_ready   = (state == S_IDLE) && req_valid;
    assign conv_ch     = ch;
    assign conv_start  = (state == S_ISSUE);
    assign res_valid   = (state == S_STORE);
    assign res_ch      = ch;
    assign res_src     = src;
    assign res_data    = data_q;
    assign timeout_err = (state == S_WAIT) && !conv_done && expired;
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_adc_scan_sched.sv
// Scoreboard bench for adc_scan_sched with a behavioural conversion engine.
module tb_adc_scan_sched;

    localparam int SETUP_CYC = 4;
    localparam int GAP_CYC   = 16;
    localparam int TIMEOUT   = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] ch_mask;
    logic       req_valid;
    logic [2:0] req_ch;
    logic       req_ready;
    logic [2:0] conv_ch;
    logic       conv_start;
    logic       conv_done;
    logic [7:0] conv_data;
    logic       res_valid;
    logic [2:0] res_ch;
    logic       res_src;
    logic [7:0] res_data;
    logic       timeout_err;
    logic       busy;
    logic [2:0] rd_ch;
    logic [7:0] rd_data;

    typedef struct {
        logic [2:0] ch;
        logic       src;
        logic [7:0] data;
        int         lat;
    } res_t;

    res_t exp_q[$];
    res_t rcv_q[$];
    res_t r;
    res_t e;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tout_cnt = 0;
    int last_tout_cyc = 0;
    int engine_mode = 0;
    int engine_delay = 10;
    int start_count = 0;
    int last_start_cyc = 0;
    int last_done_cyc = -100;
    int stray_req = 0;
    int stray_done = 0;
    logic [2:0] eng_ch;

    adc_scan_sched #(.SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
        .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
        .conv_ch(conv_ch), .conv_start(conv_start), .conv_done(conv_done),
        .conv_data(conv_data), .res_valid(res_valid), .res_ch(res_ch),
        .res_src(res_src), .res_data(res_data), .timeout_err(timeout_err),
        .busy(busy), .rd_ch(rd_ch), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine: answers a start after engine_delay cycles with data = channel * 16
    initial begin
        conv_done = 1'b0;
        conv_data = 8'h00;
        forever begin
            @(negedge clk);
            if (stray_req != stray_done) begin
                stray_done = stray_req;
                @(posedge clk); #1;
                conv_done = 1'b1;
                conv_data = 8'hAA;
                @(posedge clk); #1;
                conv_done = 1'b0;
            end else if (conv_start) begin
                start_count++;
                last_start_cyc = cyc;
                if (engine_mode == 1) begin
                    eng_ch = conv_ch;
                    repeat (engine_delay) @(posedge clk);
                    #1;
                    if (!rst) begin
                        conv_done = 1'b1;
                        conv_data = {1'b0, eng_ch, 4'h0};
                        last_done_cyc = cyc;
                        @(posedge clk); #1;
                        conv_done = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (res_valid) rcv_q.push_back('{res_ch, res_src, res_data, cyc - last_done_cyc});
        if (timeout_err) begin
            tout_cnt++;
            last_tout_cyc = cyc;
        end
    end

    task automatic test_reset();
        logic [27:0] outs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        outs = {conv_ch, conv_start, req_ready, res_valid, res_ch, res_src, res_data, timeout_err, busy, rd_data};
        total++;
        if (outs !== 28'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h want=0", outs);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) rd_ch = 3'(i);
            @(negedge clk);
            total++;
            if (rd_data !== 8'h00) begin
                bad++;
                $display("[TB] FAIL reset_regfile ch=%0d got=%h want=00", i, rd_data);
            end
        end
    endtask

    task automatic test_scan();
        int s0;
        s0 = start_count;
        engine_mode = 1;
        engine_delay = 10;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{3'd1, 1'b0, 8'h10, 1});
            exp_q.push_back('{3'd3, 1'b0, 8'h30, 1});
        end
        @(negedge clk);
        ch_mask = 8'b0000_1010;
        enable = 1'b1;
        for (int k = 0; k < 500 && start_count < s0 + 2; k++) begin
            @(negedge clk); #1;
        end
        total++;
        if (last_start_cyc - last_done_cyc !== 3 + GAP_CYC + SETUP_CYC) begin
            bad++;
            $display("[TB] FAIL scan_done_to_start got=%0d want=%0d", last_start_cyc - last_done_cyc, 3 + GAP_CYC + SETUP_CYC);
        end
        for (int k = 0; k < 1000 && exp_q.size() > 0; k++) begin
            @(negedge clk); #1;
            while (rcv_q.size() > 0 && exp_q.size() > 0) begin
                r = rcv_q.pop_front();
                e = exp_q.pop_front();
                total++;
                if (r.ch !== e.ch || r.src !== e.src || r.data !== e.data || r.lat != e.lat) begin
                    bad++;
                    $display("[TB] FAIL scan_result got ch=%0d src=%0d data=%h lat=%0d want ch=%0d src=%0d data=%h lat=%0d",
                             r.ch, r.src, r.data, r.lat, e.ch, e.src, e.data, e.lat);
                end
            end
        end
        enable = 1'b0;
        total++;
        if (exp_q.size() != 0 || rcv_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scan_drain pending=%0d extra=%0d want 0/0", exp_q.size(), rcv_q.size());
            exp_q.delete();
            rcv_q.delete();
        end
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL scan_idle busy=%b want=0", busy);
        end
        rd_ch = 3'd3;
        @(negedge clk);
        total++;
        if (rd_data !== 8'h30) begin
            bad++;
            $display("[TB] FAIL readback_ch3 got=%h want=30", rd_data);
        end
        rd_ch = 3'd1;
        @(negedge clk);
        total++;
        if (rd_data !== 8'h10) begin
            bad++;
            $display("[TB] FAIL readback_ch1 got=%h want=10", rd_data);
        end
    endtask

    task automatic test_on_demand();
        int t_acc;
        int s0;
        s0 = start_count;
        exp_q.push_back('{3'd1, 1'b0, 8'h10, 1});
        exp_q.push_back('{3'd6, 1'b1, 8'h60, 1});
        exp_q.push_back('{3'd3, 1'b0, 8'h30, 1});
        enable = 1'b1;
        for (int k = 0; k < 200 && start_count == s0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        req_ch = 3'd6;
        req_valid = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL req_ready_in_wait got=%b want=0", req_ready);
        end
        t_acc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (req_ready) begin
                t_acc = cyc;
                break;
            end
        end
        total++;
        if (t_acc < 0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL req_accept_idle accepted=%0d busy=%b want accepted in idle", t_acc >= 0, busy);
        end
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (conv_ch !== 3'd6 || cyc != t_acc + 1) begin
            bad++;
            $display("[TB] FAIL req_conv_ch got=%0d want=6", conv_ch);
        end
        for (int k = 0; k < 50 && !conv_start; k++) begin
            @(negedge clk); #1;
        end
        total++;
        if (cyc != t_acc + 1 + SETUP_CYC) begin
            bad++;
            $display("[TB] FAIL req_start_latency got=%0d want=%0d", cyc - t_acc, 1 + SETUP_CYC);
        end
        for (int k = 0; k < 1000 && exp_q.size() > 0; k++) begin
            @(negedge clk); #1;
            while (rcv_q.size() > 0 && exp_q.size() > 0) begin
                r = rcv_q.pop_front();
                e = exp_q.pop_front();
                total++;
                if (r.ch !== e.ch || r.src !== e.src || r.data !== e.data || r.lat != e.lat) begin
                    bad++;
                    $display("[TB] FAIL demand_result got ch=%0d src=%0d data=%h lat=%0d want ch=%0d src=%0d data=%h lat=%0d",
                             r.ch, r.src, r.data, r.lat, e.ch, e.src, e.data, e.lat);
                end
            end
        end
        enable = 1'b0;
        total++;
        if (exp_q.size() != 0 || rcv_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL demand_drain pending=%0d extra=%0d want 0/0", exp_q.size(), rcv_q.size());
            exp_q.delete();
            rcv_q.delete();
        end
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    endtask

    task automatic test_timeout();
        int s_cyc;
        int t0;
        int s0;
        s0 = start_count;
        t0 = tout_cnt;
        engine_mode = 0;
        enable = 1'b1;
        for (int k = 0; k < 200 && start_count == s0; k++) @(negedge clk);
        s_cyc = last_start_cyc;
        for (int k = 0; k < TIMEOUT + 20 && tout_cnt == t0; k++) begin
            @(negedge clk); #1;
        end
        total++;
        if (tout_cnt != t0 + 1 || last_tout_cyc != s_cyc + TIMEOUT) begin
            bad++;
            $display("[TB] FAIL timeout_cycle got=%0d want=%0d", last_tout_cyc - s_cyc, TIMEOUT);
        end
        engine_mode = 1;
        exp_q.push_back('{3'd3, 1'b0, 8'h30, 1});
        for (int k = 0; k < 500 && exp_q.size() > 0; k++) begin
            @(negedge clk); #1;
            while (rcv_q.size() > 0 && exp_q.size() > 0) begin
                r = rcv_q.pop_front();
                e = exp_q.pop_front();
                total++;
                if (r.ch !== e.ch || r.src !== e.src || r.data !== e.data || r.lat != e.lat) begin
                    bad++;
                    $display("[TB] FAIL timeout_next got ch=%0d src=%0d data=%h want ch=%0d src=%0d data=%h",
                             r.ch, r.src, r.data, e.ch, e.src, e.data);
                end
            end
        end
        enable = 1'b0;
        total++;
        if (exp_q.size() != 0 || rcv_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL timeout_drain pending=%0d extra=%0d want 0/0", exp_q.size(), rcv_q.size());
            exp_q.delete();
            rcv_q.delete();
        end
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        rd_ch = 3'd1;
        @(negedge clk);
        total++;
        if (rd_data !== 8'h10) begin
            bad++;
            $display("[TB] FAIL timeout_regfile got=%h want=10", rd_data);
        end
    endtask

    task automatic test_timeout_edge();
        int t0;
        t0 = tout_cnt;
        engine_mode = 1;
        engine_delay = TIMEOUT;
        exp_q.push_back('{3'd1, 1'b0, 8'h10, 1});
        enable = 1'b1;
        for (int k = 0; k < TIMEOUT + 200 && exp_q.size() > 0; k++) begin
            @(negedge clk); #1;
            while (rcv_q.size() > 0 && exp_q.size() > 0) begin
                r = rcv_q.pop_front();
                e = exp_q.pop_front();
                total++;
                if (r.ch !== e.ch || r.src !== e.src || r.data !== e.data || r.lat != e.lat) begin
                    bad++;
                    $display("[TB] FAIL edge_result got ch=%0d data=%h lat=%0d want ch=%0d data=%h lat=%0d",
                             r.ch, r.data, r.lat, e.ch, e.data, e.lat);
                end
            end
        end
        enable = 1'b0;
        engine_delay = 10;
        total++;
        if (exp_q.size() != 0 || tout_cnt != t0) begin
            bad++;
            $display("[TB] FAIL edge_success pending=%0d timeouts=%0d want 0/0", exp_q.size(), tout_cnt - t0);
            exp_q.delete();
        end
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    endtask

    task automatic test_mask();
        int activity;
        activity = 0;
        ch_mask = 8'h00;
        enable = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy || conv_start) activity++;
        end
        total++;
        if (activity != 0) begin
            bad++;
            $display("[TB] FAIL empty_mask_activity got=%0d want=0", activity);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back('{3'd7, 1'b0, 8'h70, 1});
        ch_mask = 8'h80;
        for (int k = 0; k < 1000 && exp_q.size() > 0; k++) begin
            @(negedge clk); #1;
            while (rcv_q.size() > 0 && exp_q.size() > 0) begin
                r = rcv_q.pop_front();
                e = exp_q.pop_front();
                total++;
                if (r.ch !== e.ch || r.src !== e.src || r.data !== e.data || r.lat != e.lat) begin
                    bad++;
                    $display("[TB] FAIL ch7_result got ch=%0d data=%h want ch=%0d data=%h", r.ch, r.data, e.ch, e.data);
                end
            end
        end
        enable = 1'b0;
        total++;
        if (exp_q.size() != 0 || rcv_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL ch7_drain pending=%0d extra=%0d want 0/0", exp_q.size(), rcv_q.size());
            exp_q.delete();
            rcv_q.delete();
        end
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [27:0] outs;
        int s0;
        s0 = start_count;
        engine_mode = 0;
        ch_mask = 8'b0000_1010;
        enable = 1'b1;
        for (int k = 0; k < 200 && start_count == s0; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        outs = {conv_ch, conv_start, req_ready, res_valid, res_ch, res_src, res_data, timeout_err, busy, rd_data};
        total++;
        if (outs !== 28'd0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs got=%h want=0", outs);
        end
        repeat (2) @(negedge clk);
        rd_ch = 3'd7;
        rst = 1'b0;
        stray_req++;
        @(negedge clk);
        total++;
        if (rd_data !== 8'h00) begin
            bad++;
            $display("[TB] FAIL midreset_regfile got=%h want=00", rd_data);
        end
        repeat (20) @(negedge clk);
        #1;
        total++;
        if (rcv_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL stray_done_result got=%0d results want=0", rcv_q.size());
            rcv_q.delete();
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        ch_mask = 8'h00;
        req_valid = 1'b0;
        req_ch = 3'd0;
        rd_ch = 3'd0;
        $display("[TB] start");
        test_reset();
        test_scan();
        test_on_demand();
        test_timeout();
        test_timeout_edge();
        test_mask();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
